// File: rtl/screen_write_port.sv
// CPU-side writer for the 32x32 screen RAM: captures bus writes in the
// $0200-$05FF window into a small FIFO, drains them into the RAM write port,
// and runs a hardware fill of all 1024 screen bytes with one colour.
module screen_write_port #(
  parameter int unsigned FIFO_AW     = 2,
  parameter bit          VBLANK_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_stall,
  input  logic        fill_start,
  input  logic [7:0]  fill_color,
  output logic        fill_busy,
  input  logic        vblank,
  output logic        screen_write_en,
  output logic [10:0] screen_write_addr,
  output logic [7:0]  screen_write_data
);

  localparam int unsigned       DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN_WAIT,
    FILL
  } state_t;

  state_t             state;
  logic [18:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   drain_left;
  logic               in_valid;
  logic [18:0]        in_entry;
  logic [18:0]        head;
  logic [7:0]         fill_color_q;
  logic [10:0]        fill_addr;

  logic in_range;
  logic push;
  logic permit;
  logic readable;
  logic pop;
  logic start_accept;

  // Decode, handshake and drain qualification.
  always_comb begin
    in_range     = (cpu_addr >= 16'h0200) && (cpu_addr <= 16'h05FF);
    cpu_stall    = (count == FULL_COUNT);
    push         = cpu_we && in_range && !cpu_stall;
    permit       = !VBLANK_ONLY || vblank;
    // count includes the entry still sitting in the capture register
    readable     = (count > (FIFO_AW + 1)'(in_valid));
    pop          = readable && permit &&
                   ((state == IDLE) || ((state == DRAIN_WAIT) && (drain_left != '0)));
    start_accept = fill_start && (state == IDLE);
    head         = mem[rd_ptr];
  end

  // FIFO storage; the capture register gives the two-edge write latency.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // FIFO pointers, occupancy and capture register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_valid <= 1'b0;
      in_entry <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      in_valid <= push;
      if (push) begin
        in_entry <= {cpu_addr[10:0], cpu_wdata};
      end
      if (in_valid) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Control FSM with registered RAM write port and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      screen_write_en   <= 1'b0;
      screen_write_addr <= '0;
      screen_write_data <= '0;
      fill_busy         <= 1'b0;
      fill_color_q      <= '0;
      fill_addr         <= '0;
      drain_left        <= '0;
    end else begin
      screen_write_en <= 1'b0;
      fill_busy       <= start_accept || (state != IDLE);
      if (pop) begin
        screen_write_en   <= 1'b1;
        screen_write_addr <= head[18:8];
        screen_write_data <= head[7:0];
      end
      case (state)
        IDLE: begin
          if (fill_start) begin
            fill_color_q <= fill_color;
            // Only entries accepted up to fill_start drain ahead of the fill;
            // later pushes wait in the FIFO until the fill is finished.
            drain_left   <= count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
            state        <= DRAIN_WAIT;
          end
        end
        DRAIN_WAIT: begin
          if (drain_left == '0) begin
            fill_addr <= 11'h200;
            state     <= FILL;
          end else if (pop) begin
            drain_left <= drain_left - CNT_ONE;
          end
        end
        FILL: begin
          if (permit) begin
            screen_write_en   <= 1'b1;
            screen_write_addr <= fill_addr;
            screen_write_data <= fill_color_q;
            if (fill_addr == 11'h5FF) begin
              state <= IDLE;
            end else begin
              fill_addr <= fill_addr + 11'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
